tmds_encoder_hdmi: RTL
======================

Name: tmds_encoder_hdmi

Overview:
Multi-channel TMDS encoder for HDMI 1.4 transmission, the generalised successor to the single-channel DVI encoder. Each of NUM_CH lanes encodes one of five period types, selected per cycle: control, video data, video guard band, data-island guard band, or TERC4 data island. Every lane keeps its own running disparity counter. The block sits between the video/packet timing generator and the 10:1 serialisers.

Parameters:
NUM_CH, 3, number of TMDS data lanes (1..3); lane index k selects guard-band codes.

Ports:
i_clk  input  1  pixel clock
i_rst_n  input  1  asynchronous active-low reset
i_mode  input  3  period type: 0 control, 1 video, 2 video guard, 3 data-island guard, 4 TERC4; 5..7 treated as control
i_pixel  input  8*NUM_CH  video byte per lane; lane k at [8k+7:8k]
i_ctrl  input  2*NUM_CH  control bits {C1,C0} per lane; lane k at [2k+1:2k]
i_terc4  input  4*NUM_CH  TERC4 nibble per lane; lane k at [4k+3:4k]
o_tmds  output  10*NUM_CH  encoded symbol per lane; lane k at [10k+9:10k]; bit 0 is transmitted first

Behaviour:
- Clock and reset: one clock, i_clk. i_rst_n is asynchronous and active-low.
- On reset, all pipeline registers clear: mode=0, ctrl=0, qm=0, disparity cnt=0. Every o_tmds lane = 10'b1101010100 (control code 00).
- Latency: exactly 2 cycles for every mode. The input sampled at edge n appears on o_tmds after edge n+2.
- Stage 1 registers q_m[8:0], mode, ctrl and terc4. Stage 2 registers o_tmds and cnt.
- Stage 1, video:
  - N1(D) = number of ones in the pixel byte.
  - If N1(D)>4, or N1(D)==4 and D[0]==0, use XNOR chaining: q_m[0]=D[0], q_m[i]=q_m[i-1] XNOR D[i], q_m[8]=0.
  - Otherwise use XOR chaining with q_m[8]=1.
- Stage 2, video (mode 1):
  - n1/n0 = ones/zeros in q_m[7:0]. cnt is 5-bit signed.
  - If cnt==0 or n1==n0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
    - cnt += q_m[8] ? (n1-n0) : (n0-n1)
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - out = {1, q_m[8], ~q_m[7:0]}
    - cnt += 2*q_m[8] + (n0-n1)
  - Else:
    - out = {0, q_m[8], q_m[7:0]}
    - cnt += -2*(~q_m[8]) + (n1-n0)
- Control (mode 0 or 5..7): ctrl 00 → 1101010100, 01 → 0010101011, 10 → 0101010100, 11 → 1010101011.
- Video guard (mode 2): lanes with k mod 3 = 0 or 2 output 1011001100; k mod 3 = 1 outputs 0100110011.
- Data-island guard (mode 3):
  - Lane k mod 3 = 0 outputs TERC4 of i_terc4 (the HSYNC/VSYNC nibble).
  - All other lanes output 0100110011.
- TERC4 (mode 4), nibble 0..F →
  - 0 → 1010011100, 1 → 1001100011, 2 → 1011100100, 3 → 1011100010
  - 4 → 0101110001, 5 → 0100011110, 6 → 0110001110, 7 → 0100111100
  - 8 → 1011001100, 9 → 0100111001, A → 0110011100, B → 1011000111
  - C → 1010001110, D → 1001110001, E → 0101100011, F → 1011000011
- Disparity handling:
  - cnt updates only in mode 1.
  - Every non-video cycle at stage 2 forces cnt=0. Each video period therefore starts balanced.
  - Magnitude never exceeds 10; bench asserts this.
- Mode changes take effect cycle-exact. A video→control→video sequence loses no symbols and gives no mixed output.
- Lanes are fully independent; no cross-lane state.
- Reset mid-stream: outputs revert to 1101010100 immediately (asynchronously) and cnt clears. The first post-reset symbol reflects input sampled at the first edge after deassertion, plus 2 cycles.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs → every lane 0x354 (1101010100). Deassert mid-cycle with mode=1, pixel=0x00 → control output for 2 edges, then video symbols.
- Video run, pixel=0x00 on all lanes from cnt=0 → o_tmds lane sequence 0x100, 0x3FF, 0x100, 0x3FF (bit 9 first in the listed value); cnt sequence -8, 2, -6, 4.
- Control sweep, mode=0, ctrl 0..3 per lane → 0x354, 0x0AB, 0x154, 0x2AB at 2-cycle latency. Mode 6 with ctrl=2 → 0x154.
- Guard bands, NUM_CH=3:
  - Mode 2 → lanes {0x2CC, 0x133, 0x2CC}.
  - Mode 3 with lane0 terc4=0xC → lanes {0x28E, 0x133, 0x133}.
- TERC4 sweep, mode=4, nibble 0..F on each lane → exact 16-entry table. Then video burst → first video symbol computed with cnt=0.
- Random video (10k cycles, random pixels, periodic blanking) checked against a reference model → bit-exact match; |cnt|≤10; cnt==0 after each blanking cycle.

Source files
------------

// File: rtl/tmds_encoder_hdmi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tmds_encoder_hdmi
// Multi-lane TMDS encoder for HDMI 1.4. Each lane encodes one of five period
// types per cycle: control, video (8b/10b transition-minimised, DC balanced),
// video guard band, data-island guard band, or TERC4 data island. Every lane
// keeps its own running disparity, which is cleared on any non-video cycle.
// Two register stages: stage 1 holds q_m/mode/ctrl/terc4, stage 2 holds the
// output symbol and the disparity counter.
//
// Ports
//   i_clk     pixel clock
//   i_rst_n   asynchronous active-low reset
//   i_mode    period type: 0 ctrl, 1 video, 2 video guard, 3 DI guard,
//             4 TERC4, 5..7 ctrl
//   i_pixel   video byte per lane,      lane k at [8k+7:8k]
//   i_ctrl    {C1,C0} per lane,         lane k at [2k+1:2k]
//   i_terc4   TERC4 nibble per lane,    lane k at [4k+3:4k]
//   o_tmds    10-bit symbol per lane,   lane k at [10k+9:10k], bit 0 first
// -----------------------------------------------------------------------------
module tmds_encoder_hdmi #(
  parameter int NUM_CH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [2:0]            i_mode,
  input  logic [8*NUM_CH-1:0]   i_pixel,
  input  logic [2*NUM_CH-1:0]   i_ctrl,
  input  logic [4*NUM_CH-1:0]   i_terc4,
  output logic [10*NUM_CH-1:0]  o_tmds
);

  typedef enum logic [2:0] {
    MODE_CTRL   = 3'd0,
    MODE_VIDEO  = 3'd1,
    MODE_VGUARD = 3'd2,
    MODE_DGUARD = 3'd3,
    MODE_TERC4  = 3'd4
  } mode_e;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] GUARD_A = 10'b1011001100;
  localparam logic [9:0] GUARD_B = 10'b0100110011;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4_code(input logic [3:0] d);
    case (d)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000111;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  // Period type is common to all lanes, so one stage-1 copy is shared.
  logic [2:0] mode_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!i_rst_n) mode_q <= MODE_CTRL;
    else          mode_q <= i_mode;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    // Guard-band codes depend on the lane's position within an RGB triplet.
    localparam int LANE_SEL = k % 3;

    logic [7:0]        pix;
    logic [3:0]        n1_d;
    logic              use_xnor;
    logic [8:0]        qm_d,    qm_q;
    logic [1:0]        ctrl_q;
    logic [3:0]        terc4_q;
    logic [3:0]        n1_q;
    logic signed [5:0] cnt_ext, diff, cnt_sum;
    logic [9:0]        tmds_d,  tmds_q;
    logic signed [4:0] cnt_d,   cnt_q;

    assign pix = i_pixel[8*k +: 8];

    // Stage 1: transition-minimising chain.
    always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      n1_d     = ones8(pix);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !pix[0]);
      qm_d     = '0;
      qm_d[0]  = pix[0];
      for (int i = 1; i < 8; i++)
        qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ pix[i]) : (qm_d[i-1] ^ pix[i]);
      qm_d[8]  = ~use_xnor;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        qm_q    <= '0;
        ctrl_q  <= '0;
        terc4_q <= '0;
      end else begin
        qm_q    <= qm_d;
        ctrl_q  <= i_ctrl[2*k +: 2];
        terc4_q <= i_terc4[4*k +: 4];
      end
    end

    // Stage 2: symbol selection and DC balancing.
    always_comb begin
      tmds_d  = ctrl_code(ctrl_q);
      cnt_d   = '0;
      cnt_sum = '0;
      n1_q    = ones8(qm_q[7:0]);
      cnt_ext = {cnt_q[4], cnt_q};
      // n1 - n0 over the low byte equals 2*n1 - 8.
      diff    = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
      case (mode_q)
        MODE_VIDEO: begin
          if ((cnt_q == 5'sd0) || (n1_q == 4'd4)) begin
            tmds_d  = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_sum = qm_q[8] ? (cnt_ext + diff) : (cnt_ext - diff);
          end else if ((!cnt_q[4] && (n1_q > 4'd4)) ||
                       ( cnt_q[4] && (n1_q < 4'd4))) begin
            // Running disparity and the word lean the same way: invert.
            tmds_d  = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_sum = cnt_ext + $signed({4'b0000, qm_q[8], 1'b0}) - diff;
          end else begin
            tmds_d  = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_sum = cnt_ext - $signed({4'b0000, ~qm_q[8], 1'b0}) + diff;
          end
          cnt_d = cnt_sum[4:0];
        end
        MODE_VGUARD: tmds_d = (LANE_SEL == 1) ? GUARD_B : GUARD_A;
        // Lane 0 carries HSYNC/VSYNC as TERC4 during the data-island guard.
        MODE_DGUARD: tmds_d = (LANE_SEL == 0) ? terc4_code(terc4_q) : GUARD_B;
        MODE_TERC4:  tmds_d = terc4_code(terc4_q);
        default:     tmds_d = ctrl_code(ctrl_q);
      endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        tmds_q <= CTRL_00;
        cnt_q  <= '0;
      end else begin
        tmds_q <= tmds_d;
        cnt_q  <= cnt_d;
      end
    end

    assign o_tmds[10*k +: 10] = tmds_q;
  end

endmodule
